wb_master_port: RTL and testbench
=================================

Name: wb_master_port

Overview:
- Single-outstanding Wishbone classic-cycle initiator. It drives the slave side of the GPIO and peripheral register blocks.
- It turns a valid/ready request channel from a sequencer or CPU-side bridge into one Wishbone cycle.
- It returns read data and status on a valid/ready response channel.
- It is used as the bus master for register-level bring-up and for the on-chip GPIO test engine.

Parameters:
- AW, 8, Wishbone address width in bits.
- DW, 32, Wishbone data width in bits; fixed at 32, and any other value is a compile-time error.
- TIMEOUT_CYCLES, 16, number of cycles in BUS without ack/err before the cycle is aborted. Used only with the optional feature; legal range 2..255.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous reset, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  AW  target address
- req_dat_i  in  DW  write data
- req_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  DW  read data; 0 for writes and errors
- rsp_err_o  out  1  slave err_i seen, or timeout
- rsp_timeout_o  out  1  cycle aborted by timeout; tied 0 without the optional feature
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
- wb_adr_o  out  AW  Wishbone address
- wb_dat_o  out  DW  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects
- wb_dat_i  in  DW  Wishbone read data
- wb_ack_i, wb_err_i  in  1 each  Wishbone terminations
- busy_o  out  1  high in BUS or RSP

Behaviour:
- All outputs are registered except req_ready_o and busy_o, which decode the state.
- Reset (wb_rst_ni low, asynchronous): state IDLE; all wb_*_o = 0; rsp_* = 0; timeout counter = 0.
- Reset asserted mid-cycle drops cyc/stb immediately and discards any pending response.
- FSM states are IDLE, BUS and RSP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o at edge N: latch we/adr/dat/sel into wb_*_o, set cyc = stb = 1, go to BUS.
  - wb_cyc_o is first high in cycle N+1.
- BUS:
  - req_ready_o = 0; wb_we_o/adr/dat/sel held stable.
  - At the first edge where wb_ack_i or wb_err_i is high: clear cyc/stb, go to RSP.
  - On that same edge, rsp_dat_o = wb_dat_i if it is a read with ack, else 0.
  - On that same edge, rsp_err_o = wb_err_i.
  - If ack and err are high together, err wins: rsp_err_o = 1 and rsp_dat_o = 0.
  - With a combinational-ack slave: cyc is high for exactly 1 cycle, and rsp_valid_o is high from N+2.
- RSP:
  - rsp_valid_o = 1; rsp_* held stable while rsp_ready_i = 0.
  - When rsp_valid_o && rsp_ready_i: clear rsp_valid_o, go to IDLE.
  - Minimum request-to-request spacing is 3 cycles.
- wb_ack_i or wb_err_i arriving in IDLE or RSP is ignored.
- wb_dat_o is driven only from the latched request and is left unchanged after the cycle ends.
- Addresses and sel are passed through unmodified; no alignment checks.

Optional Feature:
- Macro: WB_MASTER_PORT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUS and increments on each BUS cycle with no termination.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, go to RSP with rsp_err_o = 1, rsp_timeout_o = 1, rsp_dat_o = 0.
  - A termination arriving on the same edge as the timeout wins; rsp_timeout_o stays 0.
- Not defined: BUS waits indefinitely; no counter logic exists; rsp_timeout_o = 0.

Decomposition:
- Package wb_master_pkg holds:
  - the state enum typedef (IDLE/BUS/RSP);
  - a packed request struct (we, adr, dat, sel);
  - localparam WB_DW = 32 and WB_SELW = 4.
- No sub-module. The FSM, output registers and timeout counter stay in one module.

Test Plan:
- Write adr=0x04, dat=0x0000_00A5, sel=4'b0001 to a combinational-ack slave:
  - wb_cyc_o high for exactly 1 cycle with the matching adr/dat/sel/we = 1;
  - rsp_valid_o at N+2 with rsp_err_o = 0 and rsp_dat_o = 0.
- Read adr=0x00 while the slave returns 0x0000_1234 with ack after 3 wait cycles:
  - cyc/stb held for 4 cycles with adr stable;
  - rsp_dat_o = 0x0000_1234.
- Slave asserts wb_ack_i and wb_err_i together on a read returning 0xFFFF_FFFF:
  - rsp_err_o = 1, rsp_dat_o = 0.
- Response backpressure: hold rsp_ready_i = 0 for 5 cycles while req_valid_i stays high:
  - req_ready_o stays 0 and rsp_* stay stable;
  - the next request is accepted on the cycle after the handshake.
- With WB_MASTER_PORT_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never responds:
  - cyc drops after 16 BUS cycles;
  - rsp_err_o = 1, rsp_timeout_o = 1.
- Assert wb_rst_ni low in BUS on its second cycle:
  - wb_cyc_o and wb_stb_o go low without waiting for a clock edge;
  - no response is produced after reset release;
  - the next request completes normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-outstanding Wishbone classic initiator.
package wb_master_pkg;

  localparam int unsigned WB_DW     = 32;
  localparam int unsigned WB_SELW   = 4;
  localparam int unsigned WB_AW_MAX = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StRsp
  } wb_state_e;

  // Address is stored at the widest supported size; the top truncates to AW.
  typedef struct packed {
    logic                 we;
    logic [WB_AW_MAX-1:0] adr;
    logic [WB_DW-1:0]     dat;
    logic [WB_SELW-1:0]   sel;
  } wb_req_t;

endpackage

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic-cycle initiator with valid/ready request and response.
// Optional bus timeout is compiled in with WB_MASTER_PORT_TIMEOUT_EN.
module wb_master_port
  import wb_master_pkg::*;
#(
  parameter int unsigned AW             = 8,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [DW-1:0] req_dat_i,
  input  logic [3:0]    req_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          rsp_timeout_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          busy_o
);

  if (DW != WB_DW) begin : g_bad_dw
    $error("wb_master_port: DW must be 32");
  end
  if (AW < 1 || AW > WB_AW_MAX) begin : g_bad_aw
    $error("wb_master_port: AW must be 1..32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_master_port: TIMEOUT_CYCLES must be 2..255");
  end

  wb_state_e     state_q, state_d;
  wb_req_t       req_q, req_d;
  logic          cyc_q, cyc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          term;
  logic          timeout_hit;

  assign term = wb_ack_i | wb_err_i;

`ifdef WB_MASTER_PORT_TIMEOUT_EN
  // Fires on the edge that would complete the TIMEOUT_CYCLES-th unterminated BUS cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;

  assign timeout_hit = (state_q == StBus) && !term && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      StIdle: if (req_valid_i) cnt_d = '0;
      StBus: begin
        if (!term) cnt_d = cnt_q + 8'd1;
        rsp_timeout_d = timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StBus;
      StBus:   if (term || timeout_hit) state_d = StRsp;
      StRsp:   if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_d.we  = req_we_i;
          req_d.adr = WB_AW_MAX'(req_adr_i);
          req_d.dat = req_dat_i;
          req_d.sel = req_sel_i;
          cyc_d     = 1'b1;
        end
      end
      StBus: begin
        if (term) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = wb_err_i;
          // err dominates a simultaneous ack, so data only passes on a clean read ack
          rsp_dat_d   = (!req_q.we && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end
      end
      StRsp: begin
        if (rsp_ready_i) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      req_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      req_q       <= req_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  if (AW < WB_AW_MAX) begin : g_adr_hi
    logic unused_adr_hi;
    assign unused_adr_hi = ^req_q.adr[WB_AW_MAX-1:AW];
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = req_q.we;
  assign wb_adr_o    = req_q.adr[AW-1:0];
  assign wb_dat_o    = req_q.dat;
  assign wb_sel_o    = req_q.sel;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port: scripted scenarios plus a randomized run scored
// against a memory-level model of the target.
module tb_wb_master_port;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [3:0]    req_sel;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [DW-1:0] rsp_dat;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_master_port #(
    .AW            (AW),
    .DW            (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_adr_i    (req_adr),
    .req_dat_i    (req_dat),
    .req_sel_i    (req_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_tmo),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack),
    .wb_err_i     (wb_err),
    .busy_o       (busy)
  );

  // Target model: terminates after slv_wait wait states, optional override of read data.
  int          slv_wait = 0;
  int          slv_cnt;
  logic        slv_ack_en = 1'b1, slv_err_en = 1'b0, slv_ovr = 1'b0;
  logic        frc_ack = 1'b0, frc_err = 1'b0;
  logic [31:0] slv_ovr_dat = '0;
  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  logic        slv_hit;

  assign slv_hit  = wb_cyc && wb_stb && (slv_cnt == slv_wait);
  assign wb_ack   = (slv_hit && slv_ack_en) || frc_ack;
  assign wb_err   = (slv_hit && slv_err_en) || frc_err;
  assign wb_dat_i = slv_ovr ? slv_ovr_dat : mem[wb_adr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (wb_cyc && wb_stb && !(wb_ack || wb_err)) slv_cnt <= slv_cnt + 1;
      else slv_cnt <= 0;
      if (wb_cyc && wb_stb && wb_we && wb_ack && !wb_err)
        for (int b = 0; b < 4; b++) if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end
  end

  typedef struct packed {
    logic [31:0] rdat;
    logic        err;
    logic        tmo;
    int          ncyc;
    int          lat;
    logic        stable;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        ok;
  } txn_res_t;

  task automatic slave_cfg(input logic ack_en, input logic err_en, input int wt,
                           input logic ovr, input logic [31:0] ovr_dat);
    slv_ack_en = ack_en; slv_err_en = err_en; slv_wait = wt;
    slv_ovr = ovr; slv_ovr_dat = ovr_dat;
  endtask

  task automatic apply_reset();
    req_valid = 1'b0; rsp_ready = 1'b0; frc_ack = 1'b0; frc_err = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request/response exchange; lat counts cycles from the accept edge to rsp_valid.
  task automatic do_txn(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int bp, output txn_res_t r);
    int g;
    r = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    req_valid = 1'b0;
    r.lat = 1; r.stable = 1'b1;
    r.adr = wb_adr; r.dat = wb_dat_o; r.sel = wb_sel; r.we = wb_we;
    while (wb_cyc && r.ncyc < 200) begin
      r.ncyc++;
      if (!wb_stb || wb_adr !== r.adr || wb_dat_o !== r.dat || wb_sel !== r.sel ||
          wb_we !== r.we || req_ready) r.stable = 1'b0;
      @(negedge clk); r.lat++;
    end
    g = 0;
    while (!rsp_valid && g < 50) begin @(negedge clk); r.lat++; g++; end
    r.ok = rsp_valid; r.rdat = rsp_dat; r.err = rsp_err; r.tmo = rsp_tmo;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== r.rdat || rsp_err !== r.err) r.stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0) r.ok = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0;
    req_adr = '0; req_dat = '0; req_sel = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want 000", {wb_cyc, wb_stb, wb_we});
    end
    n_checks++;
    if ({wb_adr, wb_dat_o, wb_sel} !== '0) begin
      n_errors++; $display("FAIL reset_bus: adr %h dat %h sel %h want 0", wb_adr, wb_dat_o, wb_sel);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_tmo} !== 3'b000 || rsp_dat !== '0) begin
      n_errors++;
      $display("FAIL reset_rsp: v%b e%b t%b d%h want 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat);
    end
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_state: ready %b busy %b want 1 0", req_ready, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_comb_write();
    txn_res_t r;
    slave_cfg(1'b1, 1'b0, 0, 1'b0, '0);
    do_txn(1'b1, 8'h04, 32'h0000_00A5, 4'b0001, 0, r);
    n_checks++;
    if (!r.ok || r.ncyc != 1 || r.lat != 2) begin
      n_errors++; $display("FAIL cw_timing: ok %b cyc %0d lat %0d want 1 1 2", r.ok, r.ncyc, r.lat);
    end
    n_checks++;
    if ({r.we, r.adr, r.dat, r.sel} !== {1'b1, 8'h04, 32'h0000_00A5, 4'b0001}) begin
      n_errors++;
      $display("FAIL cw_bus: we %b adr %h dat %h sel %b want 1 04 000000a5 0001",
               r.we, r.adr, r.dat, r.sel);
    end
    n_checks++;
    if (r.err !== 1'b0 || r.rdat !== '0) begin
      n_errors++; $display("FAIL cw_rsp: err %b dat %h want 0 0", r.err, r.rdat);
    end
    n_checks++;
    if (wb_dat_o !== 32'h0000_00A5 || wb_cyc !== 1'b0) begin
      n_errors++; $display("FAIL cw_after: dat %h cyc %b want 000000a5 0", wb_dat_o, wb_cyc);
    end
  endtask

  task automatic test_wait_read();
    txn_res_t r;
    slave_cfg(1'b1, 1'b0, 3, 1'b1, 32'h0000_1234);
    do_txn(1'b0, 8'h00, $urandom, 4'hF, 0, r);
    n_checks++;
    if (!r.ok || r.ncyc != 4 || !r.stable || r.lat != 5) begin
      n_errors++;
      $display("FAIL wr_timing: ok %b cyc %0d stable %b lat %0d want 1 4 1 5",
               r.ok, r.ncyc, r.stable, r.lat);
    end
    n_checks++;
    if (r.rdat !== 32'h0000_1234 || r.err !== 1'b0) begin
      n_errors++; $display("FAIL wr_data: dat %h err %b want 00001234 0", r.rdat, r.err);
    end
  endtask

  task automatic test_ack_err();
    txn_res_t r;
    slave_cfg(1'b1, 1'b1, 1, 1'b1, 32'hFFFF_FFFF);
    do_txn(1'b0, 8'h20, '0, 4'hF, 1, r);
    n_checks++;
    if (!r.ok || r.err !== 1'b1 || r.rdat !== '0 || r.ncyc != 2) begin
      n_errors++;
      $display("FAIL ackerr: ok %b err %b dat %h cyc %0d want 1 1 0 2", r.ok, r.err, r.rdat, r.ncyc);
    end
    slave_cfg(1'b0, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
    do_txn(1'b0, 8'h21, '0, 4'hF, 0, r);
    n_checks++;
    if (!r.ok || r.err !== 1'b1 || r.rdat !== '0) begin
      n_errors++; $display("FAIL erronly: ok %b err %b dat %h want 1 1 0", r.ok, r.err, r.rdat);
    end
  endtask

  task automatic test_stray_term();
    @(negedge clk);
    frc_ack = 1'b1; frc_err = 1'b1;
    @(negedge clk);
    frc_ack = 1'b0; frc_err = 1'b0;
    n_checks++;
    if (wb_cyc !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_idle: cyc %b rsp_valid %b busy %b want 0 0 0", wb_cyc, rsp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int   g;
    logic bad;
    slave_cfg(1'b1, 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h40; req_dat = '0; req_sel = 4'hF;
    @(negedge clk);
    req_we = 1'b1; req_adr = 8'h41; req_dat = 32'h0BAD_F00D; req_sel = 4'b1100;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    for (int i = 0; i < 5; i++) begin
      bad = (req_ready !== 1'b0) || (rsp_valid !== 1'b1) || (rsp_dat !== 32'hDEAD_BEEF) ||
            (rsp_err !== 1'b0) || (wb_cyc !== 1'b0);
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL bp_hold%0d: ready %b valid %b dat %h err %b cyc %b want 0 1 deadbeef 0 0",
                 i, req_ready, rsp_valid, rsp_dat, rsp_err, wb_cyc);
      end
      frc_ack = (i == 2); frc_err = (i == 2);
      @(negedge clk);
    end
    frc_ack = 1'b0; frc_err = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_hs: ready %b valid %b cyc %b want 1 0 0", req_ready, rsp_valid, wb_cyc);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (wb_cyc !== 1'b1 || wb_adr !== 8'h41 || wb_we !== 1'b1 || wb_sel !== 4'b1100) begin
      n_errors++;
      $display("FAIL bp_next: cyc %b adr %h we %b sel %b want 1 41 1 1100",
               wb_cyc, wb_adr, wb_we, wb_sel);
    end
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== '0) begin
      n_errors++;
      $display("FAIL bp_second: valid %b err %b dat %h want 1 0 0", rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef WB_MASTER_PORT_TIMEOUT_EN
    txn_res_t r;
    slave_cfg(1'b0, 1'b0, 0, 1'b1, 32'h5A5A_5A5A);
    do_txn(1'b0, 8'h30, '0, 4'hF, 0, r);
    n_checks++;
    if (!r.ok || r.ncyc != TMO || r.err !== 1'b1 || r.tmo !== 1'b1 || r.rdat !== '0) begin
      n_errors++;
      $display("FAIL tmo_fire: ok %b cyc %0d err %b tmo %b dat %h want 1 %0d 1 1 0",
               r.ok, r.ncyc, r.err, r.tmo, r.rdat, TMO);
    end
    slave_cfg(1'b1, 1'b0, TMO - 1, 1'b1, 32'h5A5A_5A5A);
    do_txn(1'b0, 8'h31, '0, 4'hF, 0, r);
    n_checks++;
    if (!r.ok || r.ncyc != TMO || r.err !== 1'b0 || r.tmo !== 1'b0 || r.rdat !== 32'h5A5A_5A5A) begin
      n_errors++;
      $display("FAIL tmo_race: ok %b cyc %0d err %b tmo %b dat %h want 1 %0d 0 0 5a5a5a5a",
               r.ok, r.ncyc, r.err, r.tmo, r.rdat, TMO);
    end
`else
    slave_cfg(1'b0, 1'b0, 0, 1'b1, 32'h5A5A_5A5A);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h30; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL notmo_wait: cyc %b valid %b want 1 0", wb_cyc, rsp_valid);
    end
    frc_ack = 1'b1;
    @(negedge clk);
    frc_ack = 1'b0;
    n_checks++;
    if (wb_cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_tmo !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_dat !== 32'h5A5A_5A5A) begin
      n_errors++;
      $display("FAIL notmo_end: cyc %b valid %b tmo %b err %b dat %h want 0 1 0 0 5a5a5a5a",
               wb_cyc, rsp_valid, rsp_tmo, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    txn_res_t r;
    logic     seen;
    slave_cfg(1'b0, 1'b0, 0, 1'b0, '0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h10; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b1) begin
      n_errors++; $display("FAIL rm_pre: cyc %b want 1", wb_cyc);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      n_errors++; $display("FAIL rm_async: cyc %b stb %b want 0 0", wb_cyc, wb_stb);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL rm_quiet: activity after reset got 1 want 0");
    end
    slave_cfg(1'b1, 1'b0, 1, 1'b1, 32'hCAFE_0001);
    do_txn(1'b0, 8'h10, '0, 4'hF, 0, r);
    n_checks++;
    if (!r.ok || r.rdat !== 32'hCAFE_0001 || r.err !== 1'b0 || r.ncyc != 2) begin
      n_errors++;
      $display("FAIL rm_next: ok %b dat %h err %b cyc %0d want 1 cafe0001 0 2",
               r.ok, r.rdat, r.err, r.ncyc);
    end
  endtask

  task automatic test_random();
    txn_res_t    r;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat, exp_dat;
    logic [3:0]  sel;
    logic        exp_err;
    int          wt, mode;
    apply_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    for (int t = 0; t < 60; t++) begin
      we   = 1'($urandom);
      adr  = 8'($urandom_range(0, 15));
      dat  = $urandom;
      sel  = 4'($urandom);
      wt   = $urandom_range(0, 3);
      mode = $urandom_range(0, 9);
      slave_cfg(mode != 8, mode >= 8, wt, 1'b0, '0);
      exp_err = (mode >= 8);
      exp_dat = '0;
      if (!exp_err && we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) model_mem[adr][8*b +: 8] = dat[8*b +: 8];
      end else if (!exp_err) begin
        exp_dat = model_mem[adr];
      end
      do_txn(we, adr, dat, sel, $urandom_range(0, 2), r);
      n_checks++;
      if (!r.ok || !r.stable || r.ncyc != wt + 1 || r.err !== exp_err || r.rdat !== exp_dat ||
          r.tmo !== 1'b0) begin
        n_errors++;
        $display("FAIL rand%0d: ok %b stb %b cyc %0d err %b dat %h, want cyc %0d err %b dat %h",
                 t, r.ok, r.stable, r.ncyc, r.err, r.rdat, wt + 1, exp_err, exp_dat);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_comb_write();
    test_wait_read();
    test_ack_err();
    test_stray_term();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
